// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: central stall/flush sequencer for the five-stage pipeline.
// Optional stall-cycle counter is built when PIPE_STALL_PERF_EN is defined.
module pipe_stall_ctrl #(
    parameter int MC_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_req_id,
    input  logic            mc_start,
    input  logic [MC_W-1:0] mc_cycles,
    input  logic            flush_req,
    input  logic [31:0]     flush_pc,
    input  logic            perf_clr,
    output logic [5:0]      stall_en,
    output logic            flush,
    output logic [31:0]     new_pc,
    output logic            mc_busy,
    output logic            mc_done,
    output logic [31:0]     stall_cycles
);

    typedef enum logic [1:0] {
        IDLE,
        MC_RUN,
        POST_FLUSH
    } state_t;

    localparam logic [5:0]      STALL_EX = 6'b001111;
    localparam logic [5:0]      STALL_ID = 6'b000111;
    localparam logic [MC_W-1:0] ONE      = MC_W'(1);

    state_t          state;
    state_t          state_nxt;
    logic [MC_W-1:0] cnt;
    logic [MC_W-1:0] cnt_nxt;

    // State and remaining-stall countdown registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state and same-cycle stall/flush outputs; flush beats everything
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall_en  = '0;
        flush     = 1'b0;
        new_pc    = '0;
        mc_done   = 1'b0;
        if (flush_req) begin
            flush     = 1'b1;
            new_pc    = flush_pc;
            state_nxt = POST_FLUSH;
            cnt_nxt   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (mc_start && mc_cycles != '0) begin
                        stall_en = STALL_EX;
                    end else if (stall_req_id) begin
                        stall_en = STALL_ID;
                    end
                    if (mc_start) begin
                        if (mc_cycles <= ONE) begin
                            mc_done = 1'b1;
                        end else begin
                            state_nxt = MC_RUN;
                            cnt_nxt   = mc_cycles - ONE;
                        end
                    end
                end
                MC_RUN: begin
                    stall_en = STALL_EX;
                    cnt_nxt  = cnt - ONE;
                    if (cnt == ONE) begin
                        mc_done   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                POST_FLUSH: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign mc_busy = (state == MC_RUN);

`ifdef PIPE_STALL_PERF_EN
    logic [31:0] perf_cnt;

    // Saturating count of stalled cycles; clear wins over increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_cnt <= '0;
        end else if (perf_clr) begin
            perf_cnt <= '0;
        end else if (stall_en != '0 && perf_cnt != 32'hFFFF_FFFF) begin
            perf_cnt <= perf_cnt + 32'd1;
        end
    end

    assign stall_cycles = perf_cnt;
`else
    logic unused_perf_clr;
    assign unused_perf_clr = perf_clr;
    assign stall_cycles    = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed and random checks of pipe_stall_ctrl
// against a behavioural model of remaining stall cycles.
module tb_pipe_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_req_id = 1'b0;
    logic        mc_start = 1'b0;
    logic [5:0]  mc_cycles = '0;
    logic        flush_req = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        perf_clr = 1'b0;
    logic [5:0]  stall_en;
    logic        flush;
    logic [31:0] new_pc;
    logic        mc_busy;
    logic        mc_done;
    logic [31:0] stall_cycles;

    int compared = 0;
    int mismatched = 0;

    // model: m_rem = stalled cycles still owed by the running op
    // (0 when no op runs), m_pf = cycle right after a flush
    int     m_rem = 0;
    bit     m_pf = 1'b0;
    longint m_perf = 0;
    int     n_rem = 0;
    bit     n_pf = 1'b0;
    longint n_perf = 0;

    pipe_stall_ctrl #(.MC_W(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall_req_id (stall_req_id),
        .mc_start     (mc_start),
        .mc_cycles    (mc_cycles),
        .flush_req    (flush_req),
        .flush_pc     (flush_pc),
        .perf_clr     (perf_clr),
        .stall_en     (stall_en),
        .flush        (flush),
        .new_pc       (new_pc),
        .mc_busy      (mc_busy),
        .mc_done      (mc_done),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s at %0t: got %h expected %h",
                     nm, $time, got, exp);
        end
    endtask

    // compare every cycle at the falling edge, then prepare model update
    always @(negedge clk) begin
        int         cur;
        bit         can_start;
        logic [5:0] es;
        bit         ed;
        can_start = (m_rem == 0) && !m_pf && mc_start;
        cur = (m_rem > 0) ? m_rem : (can_start ? int'(mc_cycles) : 0);
        es = 6'b000000;
        ed = 1'b0;
        if (flush_req) begin
            n_rem = 0;
            n_pf  = 1'b1;
        end else begin
            if (cur >= 1) es = 6'b001111;
            else if (stall_req_id && !m_pf) es = 6'b000111;
            ed = (cur <= 1) && (m_rem > 0 || can_start);
            n_rem = (cur > 0) ? cur - 1 : 0;
            n_pf  = 1'b0;
        end
        if (perf_clr) n_perf = 0;
        else if (es != 0 && m_perf < 64'h0000_0000_FFFF_FFFF)
            n_perf = m_perf + 1;
        else n_perf = m_perf;
        cmp("stall_en", 32'(stall_en), 32'(es));
        cmp("flush", 32'(flush), 32'(flush_req));
        cmp("new_pc", new_pc, flush_req ? flush_pc : 32'h0);
        cmp("mc_busy", 32'(mc_busy), 32'(m_rem > 0));
        cmp("mc_done", 32'(mc_done), 32'(ed));
`ifdef PIPE_STALL_PERF_EN
        cmp("stall_cycles", stall_cycles, m_perf[31:0]);
`else
        cmp("stall_cycles", stall_cycles, 32'h0);
`endif
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_rem  = 0;
            m_pf   = 1'b0;
            m_perf = 0;
        end else begin
            m_rem  = n_rem;
            m_pf   = n_pf;
            m_perf = n_perf;
        end
    end

    task automatic step(input bit id, input bit st, input logic [5:0] n,
                        input bit fr, input logic [31:0] pc, input bit clr);
        @(posedge clk);
        #1;
        stall_req_id = id;
        mc_start     = st;
        mc_cycles    = n;
        flush_req    = fr;
        flush_pc     = pc;
        perf_clr     = clr;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 6'd0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        // reset state, outputs low while reset is held
        cmp("rst_stall_en", 32'(stall_en), 32'h0);
        cmp("rst_busy", 32'(mc_busy), 32'h0);
        cmp("rst_cycles", stall_cycles, 32'h0);
        reset = 1'b0;
        idle();

        // load-use stall for two cycles
        step(1'b1, 1'b0, 6'd0, 1'b0, 32'h0, 1'b0);
        #1 cmp("id_c0", 32'(stall_en), 32'h07);
        step(1'b1, 1'b0, 6'd0, 1'b0, 32'h0, 1'b0);
        #1 cmp("id_c1", 32'(stall_en), 32'h07);
        idle();
        #1 cmp("id_c2", 32'(stall_en), 32'h00);

        // four-cycle multi-cycle op
        step(1'b0, 1'b1, 6'd4, 1'b0, 32'h0, 1'b0);
        #1 cmp("mc4_c0_st", 32'(stall_en), 32'h0F);
        cmp("mc4_c0_busy", 32'(mc_busy), 32'h0);
        cmp("mc4_c0_done", 32'(mc_done), 32'h0);
        for (int c = 1; c <= 3; c++) begin
            idle();
            #1 cmp("mc4_st", 32'(stall_en), 32'h0F);
            cmp("mc4_busy", 32'(mc_busy), 32'h1);
            cmp("mc4_done", 32'(mc_done), (c == 3) ? 32'h1 : 32'h0);
        end
        idle();
        #1 cmp("mc4_c4_st", 32'(stall_en), 32'h00);
        cmp("mc4_c4_busy", 32'(mc_busy), 32'h0);

        // N=0 and N=1
        step(1'b0, 1'b1, 6'd0, 1'b0, 32'h0, 1'b0);
        #1 cmp("mc0_st", 32'(stall_en), 32'h00);
        cmp("mc0_done", 32'(mc_done), 32'h1);
        step(1'b0, 1'b1, 6'd1, 1'b0, 32'h0, 1'b0);
        #1 cmp("mc1_st", 32'(stall_en), 32'h0F);
        cmp("mc1_done", 32'(mc_done), 32'h1);
        idle();
        #1 cmp("mc1_after", 32'(stall_en), 32'h00);
        cmp("mc1_busy", 32'(mc_busy), 32'h0);

        // flush in cycle 2 of an N=6 op with load-use held high
        step(1'b1, 1'b1, 6'd6, 1'b0, 32'h0, 1'b0);
        #1 cmp("fl_c0", 32'(stall_en), 32'h0F);
        step(1'b1, 1'b0, 6'd0, 1'b0, 32'h0, 1'b0);
        #1 cmp("fl_c1", 32'(stall_en), 32'h0F);
        step(1'b1, 1'b0, 6'd0, 1'b1, 32'h0000_0180, 1'b0);
        #1 cmp("fl_flush", 32'(flush), 32'h1);
        cmp("fl_pc", new_pc, 32'h0000_0180);
        cmp("fl_st", 32'(stall_en), 32'h00);
        cmp("fl_done", 32'(mc_done), 32'h0);
        step(1'b1, 1'b0, 6'd0, 1'b0, 32'h0, 1'b0);
        #1 cmp("fl_post", 32'(stall_en), 32'h00);
        step(1'b1, 1'b0, 6'd0, 1'b0, 32'h0, 1'b0);
        #1 cmp("fl_next", 32'(stall_en), 32'h07);
        idle();

        // reset in the middle of a ten-cycle op
        step(1'b0, 1'b1, 6'd10, 1'b0, 32'h0, 1'b0);
        idle();
        idle();
        idle();
        #1 reset = 1'b1;
        #1 cmp("rmid_st", 32'(stall_en), 32'h00);
        cmp("rmid_busy", 32'(mc_busy), 32'h0);
        cmp("rmid_done", 32'(mc_done), 32'h0);
        cmp("rmid_flush", 32'(flush), 32'h0);
        cmp("rmid_pc", new_pc, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        idle();
        #1 cmp("rmid_after", 32'(stall_en), 32'h00);
        cmp("rmid_after_busy", 32'(mc_busy), 32'h0);

`ifdef PIPE_STALL_PERF_EN
        // counter preload, clear, saturation
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int c = 0; c < 5; c++)
            step(1'b1, 1'b0, 6'd0, 1'b0, 32'h0, 1'b0);
        idle();
        #1 cmp("perf_5", stall_cycles, 32'd5);
        step(1'b1, 1'b0, 6'd0, 1'b0, 32'h0, 1'b1);
        idle();
        #1 cmp("perf_clr", stall_cycles, 32'd0);
        @(posedge clk);
        #1 force dut.perf_cnt = 32'hFFFF_FFFE;
        m_perf = 64'h0000_0000_FFFF_FFFE;
        #1 release dut.perf_cnt;
        for (int c = 0; c < 3; c++)
            step(1'b1, 1'b0, 6'd0, 1'b0, 32'h0, 1'b0);
        idle();
        #1 cmp("perf_sat", stall_cycles, 32'hFFFF_FFFF);
`endif

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            logic [5:0] n;
            n = ($urandom_range(0, 15) == 0) ? 6'd63
                                              : 6'($urandom_range(0, 9));
            step($urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0, n,
                 $urandom_range(0, 15) == 0, $urandom,
                 $urandom_range(0, 31) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #2 reset = 1'b1;
                @(posedge clk);
                #1 reset = 1'b0;
            end
        end
        idle();
        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Central stall/flush sequencer for the five-stage pipeline. Collects the ID-stage load-use hazard request, runs the countdown for multi-cycle EX operations (mult-accumulate, divide), and accepts flush requests from MEM. It drives the 6-bit `stall_en` bus consumed by every pipeline buffer, and the flush/redirect signals consumed by PC and the stage buffers.

`stall_en` bit map: 0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM, 5 = WB. A stage buffer whose bit is 1 while the next-higher bit is 0 emits a bubble.

## Interface
Parameters:
- `MC_W`, default 6: width of the multi-cycle length field.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `stall_req_id` input 1: level; load-use hazard detected in ID this cycle.
- `mc_start` input 1: one-cycle pulse; EX begins a multi-cycle op.
- `mc_cycles` input MC_W: stall length for the op, sampled only with `mc_start`.
- `flush_req` input 1: level; exception or redirect from MEM.
- `flush_pc` input 32: redirect target, valid with `flush_req`.
- `perf_clr` input 1: synchronous clear of the stall counter.
- `stall_en` output 6: per-stage hold bus.
- `flush` output 1: clear all stage buffers this cycle.
- `new_pc` output 32: redirect target; equals `flush_pc` while `flush`=1, else 0.
- `mc_busy` output 1: high while the state is MC_RUN.
- `mc_done` output 1: one-cycle pulse in the last stalled cycle of a multi-cycle op.
- `stall_cycles` output 32: count of cycles with `stall_en`≠0.

## Operation
States:
- IDLE: reset state.
- MC_RUN: a multi-cycle op is in progress. Register `cnt` (MC_W bits) holds the remaining stall cycles, including the current cycle.
- POST_FLUSH: one cycle immediately after a flush.

Output priority, combinational from state and inputs:
1. `flush_req`=1: `flush`=1, `new_pc`=`flush_pc`, `stall_en`=6'b000000. Next state is POST_FLUSH and `cnt` is cleared. A flush aborts MC_RUN, and `mc_done` is not pulsed.
2. EX stall, `stall_en`=6'b001111 (bubble into MEM). Applies when:
   - the state is MC_RUN, or
   - the state is IDLE with `mc_start`=1 and `mc_cycles`≥1.
3. ID stall, `stall_en`=6'b000111 (bubble into EX). Applies when `stall_req_id`=1 and the state is not POST_FLUSH.
4. Otherwise `stall_en`=0.

Multi-cycle sequencing (N = `mc_cycles` at `mc_start`, state IDLE):
- N=0: no stall; `mc_done`=1 in the start cycle.
- N=1: stall in the start cycle only; `mc_done`=1 in that cycle; state stays IDLE.
- N≥2: stall in the start cycle, `cnt`←N−1, next state MC_RUN.
- In MC_RUN: stall every cycle and decrement `cnt`. When `cnt`=1, pulse `mc_done` and return to IDLE.
- Net effect: exactly N consecutive stalled cycles, with `mc_done` in the Nth.

Other rules:
- `mc_start` is ignored in MC_RUN and in POST_FLUSH.
- `stall_req_id` is also masked in POST_FLUSH, because ID holds flushed contents.
- POST_FLUSH always returns to IDLE after one cycle, unless `flush_req` is high again, in which case it stays in POST_FLUSH.

## Timing
- All outputs are combinational from registered state plus the current inputs. There is no added latency: a request stalls the pipeline in the same cycle it is raised.
- State, `cnt` and the counter update on the rising `clk` edge.
- `reset` asserted at any time, including mid-MC_RUN, immediately forces:
  - state=IDLE, `cnt`=0, `stall_cycles`=0;
  - with inputs low: `stall_en`=0, `flush`=0, `new_pc`=0, `mc_busy`=0, `mc_done`=0.
- Simultaneous `stall_req_id` and EX stall: the EX pattern 6'b001111 wins.
- `cnt` never wraps: it is loaded only at N≥2 and leaves MC_RUN at 1.

## Configuration
Macro `PIPE_STALL_PERF_EN`.
- Defined:
  - `stall_cycles` increments on each clock where `stall_en`≠0.
  - It saturates at 32'hFFFFFFFF.
  - `perf_clr` zeroes it at the next edge and takes priority over the increment.
- Undefined:
  - the counter is not synthesized;
  - `stall_cycles` is tied to 0 and `perf_clr` is ignored.

## Test plan
- Reset mid-op: `mc_start` with `mc_cycles`=10, then assert `reset` at cycle 3 → all outputs 0 asynchronously, state IDLE, no `mc_done`.
- `stall_req_id` high for 2 cycles in IDLE → `stall_en`=6'b000111 in exactly those 2 cycles, then 0.
- `mc_start` with `mc_cycles`=4:
  - `stall_en`=6'b001111 for cycles 0–3;
  - `mc_busy` high for cycles 1–3;
  - `mc_done` only in cycle 3;
  - `stall_en`=0 in cycle 4.
  - Repeat with N=0 and N=1 → `mc_done` in the start cycle, with 0 and 1 stalled cycles respectively.
- `flush_req` with `flush_pc`=32'h0000_0180 at cycle 2 of an N=6 op, `stall_req_id` held high throughout:
  - cycle 2: `flush`=1, `new_pc`=32'h180, `stall_en`=0, no `mc_done`;
  - next cycle (POST_FLUSH): `stall_en`=0;
  - following cycle: `stall_en`=6'b000111.
- With `PIPE_STALL_PERF_EN`: preload the counter via 5 stalled cycles → `stall_cycles`=5. `perf_clr` together with a stall → 0. A forced-saturation check holds at 32'hFFFFFFFF.
